// File: rtl/cv_ctrl_mux.sv
// cv_ctrl_mux: ColecoVision DB9 front end (keypad/joystick mux, spinner quadrature, autofire under CV_CTRL_AUTOFIRE_EN).
// Registered outputs with 1-ce latency; no backpressure, all state advances only on ce.
module cv_ctrl_mux #(
   parameter int NUM_PORTS    = 2,
   parameter int QUAD_DIV     = 32,
   parameter int ACC_W        = 10,
   parameter int AUTOFIRE_DIV = 4096
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ce,
   input  logic [32*NUM_PORTS-1:0] joy_i,
   input  logic [9*NUM_PORTS-1:0]  spinner_i,
   input  logic [NUM_PORTS-1:0]    sel_key_n_i,
   input  logic [NUM_PORTS-1:0]    sel_joy_n_i,
   output logic [4*NUM_PORTS-1:0]  ctrl_o,
   output logic [NUM_PORTS-1:0]    fire_n_o,
   output logic [2*NUM_PORTS-1:0]  quad_o
);

   localparam int DIV_W = (QUAD_DIV > 2) ? $clog2(QUAD_DIV) : 1;
   localparam logic signed [ACC_W+1:0] ACC_MAX = (ACC_W+2)'((2 ** (ACC_W-1)) - 1);
   localparam logic signed [ACC_W+1:0] ACC_MIN = (ACC_W+2)'(-(2 ** (ACC_W-1)));

   function automatic logic [3:0] key_code(input logic [31:0] jw);
      logic [3:0] c;
      if      (jw[8])  c = 4'b0011;
      else if (jw[9])  c = 4'b1110;
      else if (jw[10]) c = 4'b1101;
      else if (jw[11]) c = 4'b0110;
      else if (jw[12]) c = 4'b0001;
      else if (jw[13]) c = 4'b1001;
      else if (jw[14]) c = 4'b0111;
      else if (jw[15]) c = 4'b1100;
      else if (jw[16]) c = 4'b1000;
      else if (jw[17]) c = 4'b1011;
      else if (jw[6])  c = 4'b1010;
      else if (jw[7])  c = 4'b0101;
      else if (jw[18]) c = 4'b0100;
      else if (jw[19]) c = 4'b0010;
      else             c = 4'b1111;
      return c;
   endfunction

`ifndef CV_CTRL_AUTOFIRE_EN
   logic unused_cfg;
   assign unused_cfg = (AUTOFIRE_DIV > 1);
`endif

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [31:0]             j;
      logic [8:0]              sp;
      logic                    fire1, fire2;
      logic [3:0]              key_nib, joy_nib;
      logic                    key_f, joy_f;
      logic [DIV_W-1:0]        div_q;
      logic [1:0]              phase_q, phase_d;
      logic signed [ACC_W-1:0] acc_q, acc_d;
      logic signed [ACC_W+1:0] acc_x, delta_x, adj_x, sum_x;
      logic                    tog_q, tog_vld_q;
      logic [3:0]              ctrl_q;
      logic                    fire_q;
      logic                    tc, cap, step_up, step_dn;
      logic                    unused_hi;

      assign j  = joy_i[32*p +: 32];
      assign sp = spinner_i[9*p +: 9];

`ifdef CV_CTRL_AUTOFIRE_EN
      localparam int AF_W = (AUTOFIRE_DIV > 2) ? $clog2(AUTOFIRE_DIV) : 1;
      logic [AF_W-1:0] af_cnt_q;
      logic            af_ph_q;

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            af_cnt_q <= '0;
            af_ph_q  <= 1'b0;
         end else if (ce) begin
            if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
               af_cnt_q <= '0;
               af_ph_q  <= ~af_ph_q;
            end else begin
               af_cnt_q <= af_cnt_q + AF_W'(1);
            end
         end
      end

      // Autofire releases the held button during the high half of the phase.
      assign fire1     = j[4] & ~(j[20] & af_ph_q);
      assign fire2     = j[5] & ~(j[20] & af_ph_q);
      assign unused_hi = ^j[31:21];
`else
      assign fire1     = j[4];
      assign fire2     = j[5];
      assign unused_hi = ^j[31:20];
`endif

      assign key_nib = sel_key_n_i[p] ? 4'hF : key_code(j);
      assign key_f   = sel_key_n_i[p] | ~fire2;
      assign joy_nib = sel_joy_n_i[p] ? 4'hF : ~{j[3], j[0], j[2], j[1]};
      assign joy_f   = sel_joy_n_i[p] | ~fire1;

      assign tc      = (div_q == DIV_W'(QUAD_DIV - 1));
      assign cap     = tog_vld_q & (sp[8] ^ tog_q);
      assign step_up = tc & ~acc_q[ACC_W-1] & (acc_q != '0);
      assign step_dn = tc & acc_q[ACC_W-1];

      // Capture and step fold into one saturating add so neither is lost.
      always_comb begin
         acc_x   = {{2{acc_q[ACC_W-1]}}, acc_q};
         delta_x = cap ? {{(ACC_W-6){sp[7]}}, sp[7:0]} : '0;
         adj_x   = '0;
         phase_d = phase_q;
         if (step_up) begin
            adj_x   = '1;
            phase_d = phase_q + 2'd1;
         end else if (step_dn) begin
            adj_x   = (ACC_W+2)'(1);
            phase_d = phase_q - 2'd1;
         end
         sum_x = acc_x + delta_x + adj_x;
         if (sum_x > ACC_MAX)      acc_d = ACC_MAX[ACC_W-1:0];
         else if (sum_x < ACC_MIN) acc_d = ACC_MIN[ACC_W-1:0];
         else                      acc_d = sum_x[ACC_W-1:0];
      end

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            div_q     <= '0;
            phase_q   <= 2'd0;
            acc_q     <= '0;
            tog_q     <= 1'b0;
            tog_vld_q <= 1'b0;
            ctrl_q    <= 4'hF;
            fire_q    <= 1'b1;
         end else if (ce) begin
            div_q     <= tc ? '0 : div_q + DIV_W'(1);
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            tog_q     <= sp[8];
            tog_vld_q <= 1'b1;
            ctrl_q    <= key_nib & joy_nib;
            fire_q    <= key_f & joy_f;
         end
      end

      assign ctrl_o[4*p +: 4] = ctrl_q;
      assign fire_n_o[p]      = fire_q;
      // Gray decode of phase: 0=11, 1=10, 2=00, 3=01.
      assign quad_o[2*p +: 2] = {~phase_q[1], ~(phase_q[1] ^ phase_q[0])};
   end

endmodule

// File: tb/tb_cv_ctrl_mux.sv
// Directed bench for cv_ctrl_mux: keypad/joystick mux, spinner quadrature, saturation, autofire, reset.
module tb_cv_ctrl_mux;
   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce;
   logic [63:0] joy;
   logic [17:0] spin;
   logic [1:0]  sel_key_n;
   logic [1:0]  sel_joy_n;
   logic [7:0]  ctrl_o;
   logic [1:0]  fire_n_o;
   logic [3:0]  quad_o;

   int   vectors = 0;
   int   miscompares = 0;
   int   e_cnt = 0;
   logic af_exp;

   always #5 clk_sys = ~clk_sys;

   cv_ctrl_mux #(
      .NUM_PORTS(2), .QUAD_DIV(32), .ACC_W(10), .AUTOFIRE_DIV(4)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .ce(ce),
      .joy_i(joy), .spinner_i(spin),
      .sel_key_n_i(sel_key_n), .sel_joy_n_i(sel_joy_n),
      .ctrl_o(ctrl_o), .fire_n_o(fire_n_o), .quad_o(quad_o)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      if (ce) e_cnt++;
      #1;
   endtask

   task automatic run_to(input int n);
      int guard = 0;
      while (e_cnt < n && guard < 5000) begin
         tick();
         guard++;
      end
      if (e_cnt < n) begin
         vectors++;
         miscompares++;
         $display("FAIL run_to: reached %0d required %0d", e_cnt, n);
      end
   endtask

   task automatic flip_spin0(input logic [7:0] d);
      spin[8:0] = {~spin[8], d};
   endtask

   initial begin
      reset = 1'b1; ce = 1'b0; joy = '0; spin = '0;
      sel_key_n = 2'b11; sel_joy_n = 2'b11;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("reset_ctrl", ctrl_o, 8'hFF);
      chk("reset_fire", {6'b0, fire_n_o}, 8'h03);
      chk("reset_quad", {4'b0, quad_o}, 8'h0F);
      reset = 1'b0;

      // ce low: nothing may move
      sel_key_n = 2'b10; joy[31:0] = 32'h0000_0300;
      tick(); tick();
      chk("ce_hold", ctrl_o, 8'hFF);

      ce = 1'b1;
      tick();                                                  // E=1
      chk("key0_prio", ctrl_o, 8'hF3);
      joy[31:0] = 32'h0002_0020;
      tick();                                                  // E=2
      chk("key9", ctrl_o, 8'hFB);
      chk("fire2_key", {6'b0, fire_n_o}, 8'h02);
      joy[31:0] = 32'h0000_0010;
      tick();                                                  // E=3
      chk("fire1_keyseg_ctrl", ctrl_o, 8'hFF);
      chk("fire1_keyseg_fire", {6'b0, fire_n_o}, 8'h03);

      sel_key_n = 2'b11; joy[31:0] = '0;
      sel_joy_n = 2'b01; joy[63:32] = 32'h0000_0011;
      tick();                                                  // E=4
      chk("joy_right", ctrl_o, 8'hBF);
      chk("joy_fire1", {6'b0, fire_n_o}, 8'h01);
      sel_key_n = 2'b01; joy[63:32] = 32'h0000_1011;
      tick();                                                  // E=5
      chk("both_sel_ctrl", ctrl_o, 8'h1F);
      chk("both_sel_fire", {6'b0, fire_n_o}, 8'h01);
      sel_key_n = 2'b10; joy[31:0] = 32'h0000_0080;
      sel_joy_n = 2'b01; joy[63:32] = 32'h0000_0008;
      tick();                                                  // E=6
      chk("hash_and_up", ctrl_o, 8'h75);

      sel_key_n = 2'b11; joy[31:0] = '0; joy[63:32] = 32'h0010_0010;
      for (int i = 0; i < 8; i++) begin
         tick();                                               // E=7..14
`ifdef CV_CTRL_AUTOFIRE_EN
         af_exp = (((e_cnt - 1) / 4) % 2) == 1;
`else
         af_exp = 1'b0;
`endif
         chk("autofire", {6'b0, fire_n_o}, {6'b0, af_exp, 1'b1});
      end
      joy[63:32] = 32'h0000_0010;
      for (int i = 0; i < 4; i++) begin
         tick();                                               // E=15..18
         chk("autofire_off", {6'b0, fire_n_o}, 8'h01);
      end
      joy = '0; sel_joy_n = 2'b11;
      tick();                                                  // E=19

      // +3: steps at terminal counts 32, 64, 96
      flip_spin0(8'd3);
      run_to(31);  chk("spin_p_pre", {4'b0, quad_o}, 8'h0F);
      run_to(32);  chk("spin_p_1", {4'b0, quad_o}, 8'h0E);
      run_to(63);  chk("spin_p_1hold", {4'b0, quad_o}, 8'h0E);
      run_to(64);  chk("spin_p_2", {4'b0, quad_o}, 8'h0C);
      run_to(96);  chk("spin_p_3", {4'b0, quad_o}, 8'h0D);
      run_to(128); chk("spin_p_static", {4'b0, quad_o}, 8'h0D);

      // -2: back down through 00 then 10
      flip_spin0(8'hFE);
      run_to(159); chk("spin_n_pre", {4'b0, quad_o}, 8'h0D);
      run_to(160); chk("spin_n_1", {4'b0, quad_o}, 8'h0C);
      run_to(192); chk("spin_n_2", {4'b0, quad_o}, 8'h0E);
      run_to(224); chk("spin_n_static", {4'b0, quad_o}, 8'h0E);

      // 5 x +127 saturates at 511, then 4 x -127 leaves exactly 3
      for (int i = 0; i < 5; i++) begin
         flip_spin0(8'd127);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         flip_spin0(8'h81);
         tick();
      end
      run_to(256); chk("sat_1", {4'b0, quad_o}, 8'h0C);
      run_to(288); chk("sat_2", {4'b0, quad_o}, 8'h0D);
      run_to(320); chk("sat_3", {4'b0, quad_o}, 8'h0F);
      run_to(352); chk("sat_static", {4'b0, quad_o}, 8'h0F);

      // capture of +5 on a terminal count with acc=2 leaves acc=6
      flip_spin0(8'd3);
      tick();                                                  // E=353
      run_to(384); chk("coin_pre", {4'b0, quad_o}, 8'h0E);
      run_to(415);
      flip_spin0(8'd5);
      tick();                                                  // E=416
      chk("coin_step", {4'b0, quad_o}, 8'h0C);
      run_to(480); chk("coin_mid", {4'b0, quad_o}, 8'h0F);
      run_to(544); chk("coin_mid2", {4'b0, quad_o}, 8'h0C);
      run_to(608); chk("coin_last", {4'b0, quad_o}, 8'h0F);
      run_to(640); chk("coin_static", {4'b0, quad_o}, 8'h0F);

      // mid-run reset with acc=+5 pending
      flip_spin0(8'd6);
      tick();                                                  // E=641
      sel_joy_n = 2'b01; joy[63:32] = 32'h0000_0001;
      run_to(672);
      chk("pre_rst_quad", {4'b0, quad_o}, 8'h0E);
      chk("pre_rst_ctrl", ctrl_o, 8'hBF);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_ctrl", ctrl_o, 8'hFF);
      chk("async_rst_fire", {6'b0, fire_n_o}, 8'h03);
      chk("async_rst_quad", {4'b0, quad_o}, 8'h0F);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      chk("rst_held_ctrl", ctrl_o, 8'hFF);
      reset = 1'b0;
      e_cnt = 0;
      run_to(1);   chk("post_rst_ctrl", ctrl_o, 8'hBF);
      run_to(32);  chk("post_rst_quad", {4'b0, quad_o}, 8'h0F);
      run_to(100); chk("post_rst_static", {4'b0, quad_o}, 8'h0F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cv_ctrl_mux.md
Name: cv_ctrl_mux

Overview:
- Parametrised ColecoVision controller-port front end for NUM_PORTS players.
- Converts MiSTer-style 32-bit joystick words and 9-bit spinner words into the strobed DB9 signals the console core samples:
  - ctrl_p1..p4 (data nibble)
  - ctrl_p6 (fire)
  - ctrl_p7/ctrl_p9 (roller quadrature)
- Adds registered outputs, an accumulating spinner-to-quadrature engine and optional autofire, none of which the single-pair combinational keypad mux has.
- Sits between the sim/MiSTer top and cv_console.

Parameters:
- NUM_PORTS, 2, number of controller ports (1..4).
- QUAD_DIV, 32, ce ticks per quadrature step (≥2).
- ACC_W, 10, signed spinner accumulator width.
- AUTOFIRE_DIV, 4096, ce ticks per autofire half-period (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable (10.7 MHz strobe); all state advances only when ce=1.
- joy_i  in  32*NUM_PORTS  per-port joystick word, active-high.
  - [3:0] = R,L,D,U
  - [4] = fire1, [5] = fire2
  - [17:8] = keys 0-9
  - [6] = *, [7] = #
  - [18] = purple, [19] = blue
  - [20] = autofire enable
- spinner_i  in  9*NUM_PORTS  per port: [7:0] signed delta, [8] toggles on each new sample.
- sel_key_n_i  in  NUM_PORTS  keypad-segment select from console, active low (ctrl_p5).
- sel_joy_n_i  in  NUM_PORTS  joystick-segment select from console, active low (ctrl_p8).
- ctrl_o  out  4*NUM_PORTS  per port {p1,p2,p3,p4}, active low.
- fire_n_o  out  NUM_PORTS  per port p6, active low.
- quad_o  out  2*NUM_PORTS  per port {p7,p9} roller quadrature.

Behaviour:
- Reset values:
  - ctrl_o all 1
  - fire_n_o all 1
  - quad_o all 2'b11
  - accumulators 0, phase index 0, dividers 0, toggle trackers loaded from spinner_i[8] on first ce after reset.
- Reset applies asynchronously; a mid-operation reset abandons pending steps and clears the accumulator.
- Keypad segment (sel_key_n_i=0):
  - Priority encoder order: 0,1,...,9,*,#,purple,blue (first set wins).
  - Codes: 0=0011, 1=1110, 2=1101, 3=0110, 4=0001, 5=1001, 6=0111, 7=1100, 8=1000, 9=1011, *=1010, #=0101, purple=0100, blue=0010, none=1111.
  - Fire contribution = ~fire2.
- Joystick segment (sel_joy_n_i=0):
  - Nibble = ~{U,R,D,L} mapped onto {p1,p2,p3,p4}.
  - Fire contribution = ~fire1.
- Inactive segments contribute 1111 / 1.
- Both selects low: outputs are the bitwise AND of both contributions.
- Outputs are registered: value reflects inputs sampled on the previous ce (1-ce latency).
- Spinner capture: when spinner_i[8] differs from the stored toggle on a ce, the sign-extended delta is added to acc.
- Quadrature engine (per port):
  - Divider counts 0..QUAD_DIV-1 on ce.
  - At terminal count:
    - acc>0: phase index +1 mod 4, acc-1.
    - acc<0: phase index -1 mod 4, acc+1.
    - acc=0: hold.
  - Phase index→quad_o: 0=11, 1=10, 2=00, 3=01.
- Simultaneous capture and step in the same ce: acc_next = acc + delta ∓ 1, computed once.
- Arithmetic: acc_next is saturated to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; no wrap.
- Divider free-runs regardless of acc so step timing is deterministic.

Optional Feature:
- Macro CV_CTRL_AUTOFIRE_EN.
- Defined:
  - A per-port AUTOFIRE_DIV ce-tick counter toggles a phase bit.
  - While joy_i[20]=1 and fire1 or fire2 is held, the corresponding fire contribution is gated by the phase bit: asserted low during phase=0, high during phase=1.
  - Counter and phase reset to 0.
- Undefined: joy_i[20] is ignored; fire passes straight through; no counter logic is synthesised.

Test Plan:
- Reset asserted mid-run with acc=+5 → immediately ctrl_o=all 1, fire_n_o=1, quad_o=11; after release no quadrature steps occur.
- Port0 sel_key_n_i=0, joy_i[0]=0x0000_0300 (keys 0 and 1) → ctrl_o[3:0]=0011 one ce later; key 9 only (bit17) → 1011; fire2 set → fire_n_o[0]=0.
- Port1 sel_joy_n_i=0, joy_i[1]=0x0000_0011 (R+fire1) → ctrl_o[7:4]=1011, fire_n_o[1]=0; with both selects low and key 4 also held → 0001 & 1011 = 0001.
- Spinner delta +3 (toggle flip) with QUAD_DIV=32 → exactly 3 steps, one per 32 ce, quad_o sequence 11→10→00→01, then static; delta 0xFE (-2) → 01→00→10.
- Deltas of +127 applied repeatedly with ACC_W=10 → acc saturates at 511, never wraps negative; capture coinciding with a terminal count adds delta-1.
- CV_CTRL_AUTOFIRE_EN, AUTOFIRE_DIV=4, joy_i[20]=1, fire1 held, sel_joy_n_i=0 → fire_n_o toggles every 4 ce; clearing bit 20 → fire_n_o steady 0.
